// File: rtl/mac_ctrl_mp_if.sv
// Management bundle between the per-port MAC engines / system bus and mac_ctrl_mp.
// The master side drives status words and requests; the slave side returns accepts and read data.
interface mac_ctrl_mp_if #(
  parameter int PORT_NUM = 4
);
  logic [PORT_NUM-1:0]    rx_mgnt_valid;
  logic [20*PORT_NUM-1:0] rx_mgnt_data;
  logic [PORT_NUM-1:0]    rx_mgnt_resp;
  logic [PORT_NUM-1:0]    tx_mgnt_valid;
  logic [16*PORT_NUM-1:0] tx_mgnt_data;
  logic [PORT_NUM-1:0]    tx_mgnt_resp;
  logic                   sys_req_valid;
  logic                   sys_req_wr;
  logic [7:0]             sys_req_addr;
  logic                   sys_resp_valid;
  logic [7:0]             sys_resp_data;

  modport master (
    output rx_mgnt_valid, rx_mgnt_data, tx_mgnt_valid, tx_mgnt_data,
    output sys_req_valid, sys_req_wr, sys_req_addr,
    input  rx_mgnt_resp, tx_mgnt_resp, sys_resp_valid, sys_resp_data
  );

  modport slave (
    input  rx_mgnt_valid, rx_mgnt_data, tx_mgnt_valid, tx_mgnt_data,
    input  sys_req_valid, sys_req_wr, sys_req_addr,
    output rx_mgnt_resp, tx_mgnt_resp, sys_resp_valid, sys_resp_data
  );
endinterface

// File: rtl/mac_ctrl_mp.sv
// Multi-port MAC statistics controller: per-port rx/tx frame, byte and error counters
// updated in parallel from status handshakes, read/cleared byte-wise over the management bus.
module mac_ctrl_mp #(
  parameter int PORT_NUM    = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int CLR_ON_READ = 1,
  parameter int SATURATE    = 1
) (
  input  logic         clk,
  input  logic         rstn_sys,
  mac_ctrl_mp_if.slave bus
);
  localparam int NCNT = 6;
  localparam int IW   = $clog2(PORT_NUM * NCNT);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  cnt_t                cnt_all [PORT_NUM*NCNT];
  logic [PORT_NUM-1:0] rx_resp_q, rx_resp_d;
  logic [PORT_NUM-1:0] tx_resp_q, tx_resp_d;
  logic [31:0]         shadow_q, shadow_d;
  logic                resp_valid_q;
  logic [7:0]          resp_data_q, resp_data_d;

  logic [2:0]    req_port, req_idx;
  logic [1:0]    req_byte;
  logic          req_rd, req_wr, rd_b0, clr_all, port_ok, idx_ok;
  logic [IW-1:0] sel_ix;
  logic [31:0]   sel_val;

  assign req_port = bus.sys_req_addr[7:5];
  assign req_idx  = bus.sys_req_addr[4:2];
  assign req_byte = bus.sys_req_addr[1:0];
  assign req_rd   = bus.sys_req_valid & ~bus.sys_req_wr;
  assign req_wr   = bus.sys_req_valid & bus.sys_req_wr;
  assign rd_b0    = req_rd && (req_byte == 2'd0);
  assign clr_all  = req_wr && (bus.sys_req_addr == 8'hFF);
  assign port_ok  = int'(req_port) < PORT_NUM;
  assign idx_ok   = int'(req_idx) < NCNT;
  assign sel_ix   = IW'(int'(req_port) * NCNT + int'(req_idx));

  // Accept only when the previous cycle was not already a resp cycle.
  assign rx_resp_d = bus.rx_mgnt_valid & ~rx_resp_q;
  assign tx_resp_d = bus.tx_mgnt_valid & ~tx_resp_q;

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    logic [19:0]     rx_w;
    logic [15:0]     tx_w;
    logic            rx_acc, tx_acc, rx_good, rx_drop, rx_err;
    logic [NCNT-1:0] inc;

    assign rx_w    = bus.rx_mgnt_data[20*p +: 20];
    assign tx_w    = bus.tx_mgnt_data[16*p +: 16];
    assign rx_acc  = rx_resp_d[p];
    assign tx_acc  = tx_resp_d[p];
    assign rx_good = rx_acc && (rx_w[15:13] == 3'b000);
    assign rx_drop = rx_acc && rx_w[15];
    assign rx_err  = rx_acc && !rx_w[15] && (rx_w[13] || rx_w[14]);
    assign inc     = {tx_acc, tx_acc, rx_drop, rx_err, rx_good, rx_good};

    for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
      logic [11:0]        amt;
      logic               hit, clr;
      cnt_t               base, cnt_q, cnt_d;
      logic [CNT_WIDTH:0] sum;

      if (gi == 1) begin : g_rxlen
        assign amt = rx_w[11:0];
      end else if (gi == 5) begin : g_txlen
        assign amt = tx_w[11:0];
      end else begin : g_one
        assign amt = 12'd1;
      end

      assign hit = (req_port == 3'(p)) && (req_idx == 3'(gi));
      assign clr = clr_all || (hit && (req_wr || (rd_b0 && (CLR_ON_READ != 0))));

      // A clear coinciding with an event leaves just that event's contribution.
      always_comb begin
        base  = clr ? '0 : cnt_q;
        sum   = {1'b0, base} + {{(CNT_WIDTH + 1 - 12){1'b0}}, amt};
        cnt_d = base;
        if (inc[gi]) begin
          if (sum[CNT_WIDTH] && (SATURATE != 0)) cnt_d = '1;
          else                                   cnt_d = sum[CNT_WIDTH-1:0];
        end
      end

      always_ff @(posedge clk or negedge rstn_sys) begin
        if (!rstn_sys) cnt_q <= '0;
        else           cnt_q <= cnt_d;
      end

      assign cnt_all[p*NCNT+gi] = cnt_q;
    end
  end

  always_comb begin
    sel_val = '0;
    if (port_ok && idx_ok) sel_val[CNT_WIDTH-1:0] = cnt_all[sel_ix];
  end

  // Byte 0 snapshots the whole counter so bytes 1..3 stay coherent with it.
  always_comb begin
    shadow_d    = shadow_q;
    resp_data_d = 8'h00;
    if (req_rd) begin
      if (req_byte == 2'd0) begin
        shadow_d    = sel_val;
        resp_data_d = sel_val[7:0];
      end else begin
        resp_data_d = shadow_q[{req_byte, 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_sys) begin
    if (!rstn_sys) begin
      rx_resp_q    <= '0;
      tx_resp_q    <= '0;
      shadow_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 8'h00;
    end else begin
      rx_resp_q    <= rx_resp_d;
      tx_resp_q    <= tx_resp_d;
      shadow_q     <= shadow_d;
      resp_valid_q <= bus.sys_req_valid;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.rx_mgnt_resp   = rx_resp_q;
  assign bus.tx_mgnt_resp   = tx_resp_q;
  assign bus.sys_resp_valid = resp_valid_q;
  assign bus.sys_resp_data  = resp_data_q;
endmodule

// File: tb/tb_mac_ctrl_mp.sv
// Bench for mac_ctrl_mp: a saturating and a wrapping 16-bit instance share stimulus and are
// compared against a counter-array model of the statistics rules.
module tb_mac_ctrl_mp;
  localparam int PN = 4;
  localparam int CW = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mac_ctrl_mp_if #(.PORT_NUM(PN)) ia ();
  mac_ctrl_mp_if #(.PORT_NUM(PN)) ib ();

  mac_ctrl_mp #(.PORT_NUM(PN), .CNT_WIDTH(CW), .CLR_ON_READ(1), .SATURATE(1)) dut_sat (
    .clk(clk), .rstn_sys(rstn), .bus(ia.slave));
  mac_ctrl_mp #(.PORT_NUM(PN), .CNT_WIDTH(CW), .CLR_ON_READ(1), .SATURATE(0)) dut_wrap (
    .clk(clk), .rstn_sys(rstn), .bus(ib.slave));

  assign ib.rx_mgnt_valid = ia.rx_mgnt_valid;
  assign ib.rx_mgnt_data  = ia.rx_mgnt_data;
  assign ib.tx_mgnt_valid = ia.tx_mgnt_valid;
  assign ib.tx_mgnt_data  = ia.tx_mgnt_data;
  assign ib.sys_req_valid = ia.sys_req_valid;
  assign ib.sys_req_wr    = ia.sys_req_wr;
  assign ib.sys_req_addr  = ia.sys_req_addr;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: [dut 0 = saturating, 1 = wrapping][port 0..7][index 0..7]
  int unsigned m_cnt [2][8][8];
  int unsigned m_sh  [2];
  logic [19:0] rxw [PN];
  logic [15:0] txw [PN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      m_sh[d] = 0;
      for (int p = 0; p < 8; p++)
        for (int i = 0; i < 8; i++) m_cnt[d][p][i] = 0;
    end
  endfunction

  function automatic void m_add(int p, int i, int unsigned a);
    for (int d = 0; d < 2; d++) begin
      int unsigned s = m_cnt[d][p][i] + a;
      if (s > 65535) s = (d == 0) ? 65535 : s - 65536;
      m_cnt[d][p][i] = s;
    end
  endfunction

  function automatic void m_rx(int p, logic [19:0] w);
    if (w[15])              m_add(p, 3, 1);
    else if (w[13] | w[14]) m_add(p, 2, 1);
    else begin
      m_add(p, 0, 1);
      m_add(p, 1, int'(w[11:0]));
    end
  endfunction

  function automatic void m_tx(int p, logic [15:0] w);
    m_add(p, 4, 1);
    m_add(p, 5, int'(w[11:0]));
  endfunction

  function automatic logic [7:0] m_read(int d, logic [7:0] a);
    int p = int'(a[7:5]);
    int i = int'(a[4:2]);
    int b = int'(a[1:0]);
    if (b == 0) begin
      m_sh[d] = (p < PN && i < 6) ? m_cnt[d][p][i] : 0;
      if (p < PN && i < 6) m_cnt[d][p][i] = 0;
    end
    return 8'((m_sh[d] >> (8 * b)) & 255);
  endfunction

  function automatic void m_write(logic [7:0] a);
    for (int d = 0; d < 2; d++) begin
      if (a == 8'hFF) begin
        for (int p = 0; p < 8; p++)
          for (int i = 0; i < 8; i++) m_cnt[d][p][i] = 0;
      end else begin
        m_cnt[d][int'(a[7:5])][int'(a[4:2])] = 0;
      end
    end
  endfunction

  // One status/management transaction: acceptance cycle, then resp cycle with valid still held.
  task automatic send(input logic [PN-1:0] rxm, input logic [PN-1:0] txm, input bit req,
                      input bit wr, input logic [7:0] addr, input string tag,
                      output logic [7:0] ra);
    logic [7:0] ea, eb;
    ea = 8'h00;
    eb = 8'h00;
    for (int p = 0; p < PN; p++) begin
      ia.rx_mgnt_data[20*p +: 20] = rxw[p];
      ia.tx_mgnt_data[16*p +: 16] = txw[p];
    end
    ia.rx_mgnt_valid = rxm;
    ia.tx_mgnt_valid = txm;
    ia.sys_req_valid = req;
    ia.sys_req_wr    = wr;
    ia.sys_req_addr  = addr;
    tick();
    if (req) begin
      if (wr) m_write(addr);
      else begin
        ea = m_read(0, addr);
        eb = m_read(1, addr);
      end
    end
    for (int p = 0; p < PN; p++) begin
      if (rxm[p]) m_rx(p, rxw[p]);
      if (txm[p]) m_tx(p, txw[p]);
    end
    ra = ia.sys_resp_data;
    chk({tag, " rx_resp"}, 32'({ia.rx_mgnt_resp, ib.rx_mgnt_resp}), 32'({rxm, rxm}));
    chk({tag, " tx_resp"}, 32'({ia.tx_mgnt_resp, ib.tx_mgnt_resp}), 32'({txm, txm}));
    chk({tag, " resp_valid"}, 32'({ia.sys_resp_valid, ib.sys_resp_valid}), 32'({req, req}));
    if (req) begin
      chk({tag, " data sat"}, 32'(ia.sys_resp_data), 32'(ea));
      chk({tag, " data wrap"}, 32'(ib.sys_resp_data), 32'(eb));
    end
    ia.sys_req_valid = 1'b0;
    tick();
    chk({tag, " one-cycle resp"},
        32'({ia.rx_mgnt_resp, ia.tx_mgnt_resp, ib.rx_mgnt_resp, ib.tx_mgnt_resp,
             ia.sys_resp_valid, ib.sys_resp_valid}), 32'd0);
    ia.rx_mgnt_valid = '0;
    ia.tx_mgnt_valid = '0;
  endtask

  task automatic rd(input logic [7:0] addr, input string tag,
                    output logic [7:0] da, output logic [7:0] db);
    ia.sys_req_valid = 1'b1;
    ia.sys_req_wr    = 1'b0;
    ia.sys_req_addr  = addr;
    tick();
    ia.sys_req_valid = 1'b0;
    da = ia.sys_resp_data;
    db = ib.sys_resp_data;
    chk({tag, " rd valid"}, 32'({ia.sys_resp_valid, ib.sys_resp_valid}), 32'h3);
    chk({tag, " rd sat"}, 32'(da), 32'(m_read(0, addr)));
    chk({tag, " rd wrap"}, 32'(db), 32'(m_read(1, addr)));
  endtask

  task automatic idle(input string tag);
    tick();
    chk({tag, " idle"},
        32'({ia.rx_mgnt_resp, ia.tx_mgnt_resp, ib.rx_mgnt_resp, ib.tx_mgnt_resp,
             ia.sys_resp_valid, ib.sys_resp_valid}), 32'd0);
  endtask

  function automatic logic [19:0] rand_rx();
    logic [11:0] len = 12'($urandom);
    logic [3:0]  rsv = 4'($urandom);
    logic        tte = 1'($urandom);
    case ($urandom_range(0, 3))
      0, 1:    return {rsv, 3'b000, tte, len};
      2:       return {rsv, 1'b0, 2'($urandom_range(1, 3)), tte, len};
      default: return {rsv, 1'b1, 2'($urandom), tte, len};
    endcase
  endfunction

  initial begin
    logic [7:0] a8, b8, r8, addr;
    int         r;
    ia.rx_mgnt_valid = '0;
    ia.rx_mgnt_data  = '0;
    ia.tx_mgnt_valid = '0;
    ia.tx_mgnt_data  = '0;
    ia.sys_req_valid = 1'b0;
    ia.sys_req_wr    = 1'b0;
    ia.sys_req_addr  = 8'h00;
    for (int p = 0; p < PN; p++) begin
      rxw[p] = '0;
      txw[p] = '0;
    end
    m_reset();

    // Reset state
    tick();
    tick();
    chk("reset outputs",
        32'({ia.rx_mgnt_resp, ia.tx_mgnt_resp, ib.rx_mgnt_resp, ib.tx_mgnt_resp,
             ia.sys_resp_valid, ib.sys_resp_valid}), 32'd0);
    chk("reset data", 32'({ia.sys_resp_data, ib.sys_resp_data}), 32'd0);
    rstn = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      rd(8'(b), "reset p0 rx_good", a8, b8);
      chk("reset byte value", 32'({a8, b8}), 32'd0);
    end
    idle("after reset reads");

    // Port 2: three good frames
    rxw[2] = 20'd64;   send(4'b0100, 4'b0000, 1'b0, 1'b0, 8'h00, "p2 f64", r8);
    rxw[2] = 20'd1518; send(4'b0100, 4'b0000, 1'b0, 1'b0, 8'h00, "p2 f1518", r8);
    rxw[2] = 20'd100;  send(4'b0100, 4'b0000, 1'b0, 1'b0, 8'h00, "p2 f100", r8);
    rd(8'h40, "p2 rx_good", a8, b8); chk("p2 rx_good=3", 32'(a8), 32'h03);
    rd(8'h44, "p2 rx_bytes b0", a8, b8); chk("p2 rx_bytes b0", 32'(a8), 32'h92);
    rd(8'h45, "p2 rx_bytes b1", a8, b8); chk("p2 rx_bytes b1", 32'(a8), 32'h06);
    rd(8'h46, "p2 rx_bytes b2", a8, b8); chk("p2 rx_bytes b2", 32'(a8), 32'h00);
    rd(8'h47, "p2 rx_bytes b3", a8, b8); chk("p2 rx_bytes b3", 32'(b8), 32'h00);
    rd(8'h44, "p2 clr-on-read", a8, b8); chk("p2 cleared", 32'(a8), 32'h00);
    idle("p2");

    // Port 1: drop with CRC error counts only as drop
    rxw[1] = 20'h0A040;
    send(4'b0010, 4'b0000, 1'b0, 1'b0, 8'h00, "p1 drop", r8);
    rd(8'h2C, "p1 rx_drop", a8, b8); chk("p1 rx_drop=1", 32'(a8), 32'h01);
    rd(8'h28, "p1 rx_err", a8, b8);  chk("p1 rx_err=0", 32'(a8), 32'h00);

    // All ports tx together
    for (int p = 0; p < PN; p++) txw[p] = 16'h1040;
    send(4'b0000, 4'b1111, 1'b0, 1'b0, 8'h00, "tx all", r8);
    for (int p = 0; p < PN; p++) begin
      rd(8'(p * 32 + 16), "tx_frames", a8, b8); chk("tx_frames=1", 32'(a8), 32'h01);
      rd(8'(p * 32 + 20), "tx_bytes", a8, b8);  chk("tx_bytes=0x40", 32'(a8), 32'h40);
    end
    rd(8'hA0, "port5", a8, b8); chk("port5 reads 0", 32'({a8, b8}), 32'd0);
    rd(8'h18, "idx6", a8, b8);  chk("idx6 reads 0", 32'({a8, b8}), 32'd0);
    idle("tx");

    // Saturate (dut_sat) vs wrap (dut_wrap) at 16 bits
    send(4'b0000, 4'b0000, 1'b1, 1'b1, 8'h04, "clr p0 bytes", r8);
    rxw[0] = 20'h00FFF;
    for (int k = 0; k < 16; k++) send(4'b0001, 4'b0000, 1'b0, 1'b0, 8'h00, "preload", r8);
    rxw[0] = 20'h00020;
    send(4'b0001, 4'b0000, 1'b0, 1'b0, 8'h00, "overflow frame", r8);
    rd(8'h04, "ovf b0", a8, b8);
    chk("sat b0", 32'(a8), 32'hFF);
    chk("wrap b0", 32'(b8), 32'h10);
    rd(8'h05, "ovf b1", a8, b8);
    chk("sat b1", 32'(a8), 32'hFF);
    chk("wrap b1", 32'(b8), 32'h00);

    // Byte-0 read coinciding with a good frame
    rxw[0] = 20'h01040;
    send(4'b0000, 4'b0000, 1'b1, 1'b1, 8'h00, "clr p0 good", r8);
    for (int k = 0; k < 5; k++) send(4'b0001, 4'b0000, 1'b0, 1'b0, 8'h00, "good5", r8);
    send(4'b0001, 4'b0000, 1'b1, 1'b0, 8'h00, "coinc", r8);
    chk("coinc pre-increment", 32'(r8), 32'h05);
    rd(8'h00, "coinc after", a8, b8); chk("coinc counter=1", 32'({a8, b8}), 32'h0101);

    // Randomized traffic with concurrent management requests
    for (int it = 0; it < 300; it++) begin
      for (int p = 0; p < PN; p++) begin
        rxw[p] = rand_rx();
        txw[p] = 16'($urandom);
      end
      r    = $urandom_range(0, 19);
      addr = {3'($urandom_range(0, 4)), 3'($urandom), 2'($urandom)};
      if (r < 12)       send(4'($urandom), 4'($urandom), 1'b1, 1'b0, addr, "rnd rd", r8);
      else if (r < 15)  send(4'($urandom), 4'($urandom), 1'b0, 1'b0, addr, "rnd frm", r8);
      else if (r < 19)  send(4'($urandom), 4'($urandom), 1'b1, 1'b1, addr, "rnd wr", r8);
      else              send(4'($urandom), 4'($urandom), 1'b1, 1'b1, 8'hFF, "rnd wr all", r8);
    end
    for (int p = 0; p < PN; p++)
      for (int i = 0; i < 6; i++)
        for (int b = 0; b < 2; b++) rd(8'(p * 32 + i * 4 + b), "sweep", a8, b8);
    idle("sweep");

    // Clear everything
    for (int p = 0; p < PN; p++) begin
      rxw[p] = rand_rx();
      txw[p] = 16'($urandom);
    end
    send(4'b1111, 4'b1111, 1'b0, 1'b0, 8'h00, "prefill", r8);
    send(4'b0000, 4'b0000, 1'b1, 1'b1, 8'hFF, "clear all", r8);
    for (int p = 0; p < PN; p++)
      for (int i = 0; i < 8; i++) begin
        rd(8'(p * 32 + i * 4), "after clear all", a8, b8);
        chk("clear all zero", 32'({a8, b8}), 32'd0);
      end

    // Reset while a resp is pending
    rxw[0] = 20'h00100;
    ia.rx_mgnt_data[19:0] = rxw[0];
    ia.rx_mgnt_valid = 4'b0001;
    tick();
    chk("pre-reset resp", 32'({ia.rx_mgnt_resp[0], ib.rx_mgnt_resp[0]}), 32'h3);
    rstn = 1'b0;
    #1;
    chk("async reset resp", 32'({ia.rx_mgnt_resp, ib.rx_mgnt_resp}), 32'd0);
    ia.rx_mgnt_valid = '0;
    m_reset();
    tick();
    rstn = 1'b1;
    tick();
    rd(8'h00, "post-reset good", a8, b8); chk("post-reset good", 32'({a8, b8}), 32'd0);
    rd(8'h04, "post-reset bytes", a8, b8); chk("post-reset bytes", 32'({a8, b8}), 32'd0);
    idle("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
